// File: rtl/array_loader.sv
// Boot-time array loader: streams a size word plus N elements into data
// memory while holding the processor in reset until the load completes.
module array_loader #(
  parameter int BASE_ADDR = 0,
  parameter int MAX_SIZE  = 10,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              src_valid,
  input  logic [31:0]       src_data,
  output logic              src_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(MAX_SIZE + 1);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] SIZE_A = ADDR_W'(BASE_ADDR + MAX_SIZE);

  typedef enum logic [2:0] {
    IDLE, SIZE, DATA, DONE, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              accept;
  logic              bad_size;

  assign src_ready = (state_q == SIZE) || (state_q == DATA);
  assign accept    = src_ready && src_valid;
  assign bad_size  = (src_data == 32'd0) || (src_data > 32'(MAX_SIZE));

  assign busy      = src_ready;
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);
  assign cpu_reset = (state_q != DONE);

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = SIZE;
          cnt_d   = '0;
        end
      end
      SIZE: begin
        if (accept) begin
          if (bad_size) begin
            state_d = ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = SIZE_A;
            wdata_d = src_data;
            n_d     = src_data[CNT_W-1:0];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // start is deliberately ignored here; only acceptance matters
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = BASE_A + ADDR_W'(cnt_q);
          wdata_d = src_data;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == n_q - CNT_W'(1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
